fetch_stage: RTL and testbench

Pipelined instruction fetch stage sitting directly upstream of the decode/execute datapath. Owns the PC register, issues word reads to instruction memory, buffers returned instructions in a small in-order prefetch queue, and presents them to decode with a valid/ready handshake. Branch redirects from execute flush the queue and discard stale in-flight memory responses.

---
 rtl/fetch_stage.sv | 134 +++++++++++++
 tb/tb_fetch_stage.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : Instruction fetch: PC, credit-limited imem reads, in-order
//            prefetch queue, valid/ready hand-off to decode, branch redirect.
//            Optional FETCH_STATS_EN adds perf_fetched / perf_stall counters.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH) + 1;

    logic [31:0]        r_fetch_pc;
    logic [31:0]        r_resp_pc;
    logic [31:0]        r_inst_q [DEPTH];
    logic [31:0]        r_pc_q   [DEPTH];
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [c_CNT_W-1:0] r_inflight;
    logic [c_CNT_W-1:0] r_drop;

    logic [c_CNT_W-1:0] w_occupancy;
    logic               w_issue;
    logic               w_resp;
    logic               w_accept;
    logic               w_deq;
    logic [31:0]        w_redirect_pc;

    // Every in-flight read owns a queue slot, so the queue can never overflow.
    assign w_occupancy   = r_count + r_inflight;
    assign w_issue       = rst & ~redirect & (w_occupancy < c_CNT_W'(DEPTH));
    assign w_resp        = imem_rvalid & (r_inflight != '0);
    assign w_accept      = w_resp & (r_drop == '0);
    assign w_deq         = id_valid & id_ready;
    assign w_redirect_pc = redirect_pc & ~32'h0000_0003;

    assign imem_req  = w_issue;
    assign imem_addr = r_fetch_pc;
    assign id_valid  = (r_count != '0);
    assign id_inst   = r_inst_q[r_rd_ptr];
    assign id_pc     = r_pc_q[r_rd_ptr];
    assign id_pc4    = id_pc + 32'd4;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_fetch_pc <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_inflight <= '0;
            r_drop     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_inst_q[i] <= '0;
                r_pc_q[i]   <= '0;
            end
        end else if (redirect) begin
            // Everything still outstanding, including a word returning now, is stale.
            r_fetch_pc <= w_redirect_pc;
            r_resp_pc  <= w_redirect_pc;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_inflight <= r_inflight - c_CNT_W'(w_resp);
            r_drop     <= r_inflight - c_CNT_W'(w_resp);
        end else begin
            if (w_issue) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            r_inflight <= r_inflight + c_CNT_W'(w_issue) - c_CNT_W'(w_resp);
            if (w_resp && (r_drop != '0)) begin
                r_drop <= r_drop - c_CNT_W'(1);
            end
            if (w_accept) begin
                r_inst_q[r_wr_ptr] <= imem_rdata;
                r_pc_q[r_wr_ptr]   <= r_resp_pc;
                r_wr_ptr           <= r_wr_ptr + c_PTR_W'(1);
                r_resp_pc          <= r_resp_pc + 32'd4;
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_count <= r_count + c_CNT_W'(w_accept) - c_CNT_W'(w_deq);
        end
    end

`ifdef FETCH_STATS_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_perf_fetched <= '0;
            r_perf_stall   <= '0;
        end else begin
            if (w_deq) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
            if (id_ready && !id_valid) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_stall   = r_perf_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Directed self-checking bench for fetch_stage with an in-order
//            fixed-latency instruction memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
`ifdef FETCH_STATS_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    int          total = 0;
    int          bad   = 0;
    int          lat   = 1;
    logic        pv [4];
    logic [31:0] pa [4];
    logic        inj_v;
    logic [31:0] inj_d;
    logic [31:0] exp_pc;
    int          hs;
    int          found;

    always #5 clk = ~clk;

    fetch_stage #(.DEPTH(2), .RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_inst     (id_inst),
        .id_pc       (id_pc),
        .id_pc4      (id_pc4)
`ifdef FETCH_STATS_EN
        ,
        .perf_fetched(perf_fetched),
        .perf_stall  (perf_stall)
`endif
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_mem();
        imem_rvalid = inj_v | pv[lat-1];
        imem_rdata  = inj_v ? inj_d : (pv[lat-1] ? memf(pa[lat-1]) : 32'h0);
    endtask

    // One clock: sample the request, advance the memory pipe, drive the response.
    task automatic tick();
        logic        rq;
        logic [31:0] ad;
        logic        rs;
        #1;
        rq = (imem_req === 1'b1);
        ad = imem_addr;
        rs = rst;
        @(posedge clk);
        #1;
        for (int i = 3; i > 0; i--) begin
            pv[i] = pv[i-1];
            pa[i] = pa[i-1];
        end
        pv[0] = rq;
        pa[0] = ad;
        if (!rs) begin
            for (int i = 0; i < 4; i++) pv[i] = 1'b0;
        end
        inj_v = 1'b0;
        drive_mem();
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            if (id_valid === 1'b1 && id_ready === 1'b1) begin
                chk("hs_pc", id_pc, exp_pc);
                chk("hs_inst", id_inst, memf(exp_pc));
                chk("hs_pc4", id_pc4, exp_pc + 32'd4);
                exp_pc += 32'd4;
                hs++;
            end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; id_ready = 1'b0;
        inj_v = 1'b0; inj_d = 32'h0; exp_pc = 32'h0; hs = 0; found = 0;
        for (int i = 0; i < 4; i++) begin pv[i] = 1'b0; pa[i] = 32'h0; end
        drive_mem();
        tick();
        tick();

        chk("rst_req", imem_req, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", id_valid, 32'h0);
        chk("rst_inst", id_inst, 32'h0);
        chk("rst_pc", id_pc, 32'h0);
        chk("rst_pc4", id_pc4, 32'h4);

        // Reset release, 1-cycle memory, decode always ready
        rst = 1'b1; id_ready = 1'b1; #1;
        chk("c0_req", imem_req, 32'h1);
        chk("c0_addr", imem_addr, 32'h0);
        tick();
        chk("c1_valid", id_valid, 32'h0);
        chk("c1_req", imem_req, 32'h1);
        chk("c1_addr", imem_addr, 32'h4);
        tick();
        chk("c2_valid", id_valid, 32'h1);
        chk("c2_pc", id_pc, 32'h0);
        exp_pc = 32'h0; hs = 0;
        run(12);
        chk("t1_flow", (hs >= 6) ? 32'h1 : 32'h0, 32'h1);

        // Decode stalls for 10 cycles: queue fills, requests stop
        id_ready = 1'b0;
        run(10);
        chk("stall_req", imem_req, 32'h0);
        chk("stall_valid", id_valid, 32'h1);
        chk("stall_pc", id_pc, exp_pc);
        chk("stall_inst", id_inst, memf(exp_pc));
        id_ready = 1'b1; #1;
        chk("deq_cycle_req", imem_req, 32'h0);
        run(1);
        chk("resume_req", imem_req, 32'h1);
        run(10);

        // Redirect together with a returning word and a head handshake
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            if (id_valid === 1'b1 && imem_rvalid === 1'b1) found = 1;
            else run(1);
        end
        chk("t4_found", found, 32'h1);
        chk("t4_head_pc", id_pc, exp_pc);
        redirect = 1'b1; redirect_pc = 32'h0000_0200; #1;
        chk("t4_redir_req", imem_req, 32'h0);
        tick();
        redirect = 1'b0; #1;
        chk("t4_v1", id_valid, 32'h0);
        chk("t4_addr", imem_addr, 32'h0000_0200);
        chk("t4_req", imem_req, 32'h1);
        tick();
        chk("t4_v2", id_valid, 32'h0);
        tick();
        chk("t4_v3", id_valid, 32'h1);
        chk("t4_pc", id_pc, 32'h0000_0200);
        exp_pc = 32'h0000_0200;
        run(6);

        // Redirect to the top word: PC wraps to zero
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF; #1;
        tick();
        redirect = 1'b0; #1;
        chk("t5_addr0", imem_addr, 32'hFFFF_FFFC);
        chk("t5_req0", imem_req, 32'h1);
        tick();
        chk("t5_addr1", imem_addr, 32'h0);
        chk("t5_req1", imem_req, 32'h1);
        tick();
        chk("t5_valid", id_valid, 32'h1);
        chk("t5_pc", id_pc, 32'hFFFF_FFFC);
        chk("t5_pc4", id_pc4, 32'h0);
        exp_pc = 32'hFFFF_FFFC;
        run(6);

        // 3-cycle memory, redirect with two reads in flight
        rst = 1'b0; id_ready = 1'b0;
        tick();
        lat = 3; drive_mem();
        rst = 1'b1; #1;
        chk("t3_c0_req", imem_req, 32'h1);
        tick();
        tick();
        redirect = 1'b1; redirect_pc = 32'h0000_0102; #1;
        chk("t3_redir_req", imem_req, 32'h0);
        tick();
        redirect = 1'b0; #1;
        chk("t3_addr", imem_addr, 32'h0000_0100);
        chk("t3_credit_req", imem_req, 32'h0);
        exp_pc = 32'h0000_0100; hs = 0; id_ready = 1'b1;
        run(20);
        chk("t3_hs", (hs > 0) ? 32'h1 : 32'h0, 32'h1);

        // Reset pulse with two reads in flight, coincident redirect, late response
        rst = 1'b0; id_ready = 1'b0;
        tick();
        rst = 1'b1; #1;
        tick();
        tick();
        rst = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0500; id_ready = 1'b1; #1;
        chk("t6_rst_req", imem_req, 32'h0);
        tick();
        rst = 1'b1; redirect = 1'b0;
        inj_v = 1'b1; inj_d = 32'hDEAD_BEEF; drive_mem(); #1;
        chk("t6_valid", id_valid, 32'h0);
        chk("t6_addr", imem_addr, 32'h0);
        chk("t6_req", imem_req, 32'h1);
`ifdef FETCH_STATS_EN
        chk("t6_perf_fetched", perf_fetched, 32'h0);
        chk("t6_perf_stall", perf_stall, 32'h0);
`endif
        exp_pc = 32'h0; hs = 0;
        run(20);
        chk("t6_hs", (hs > 0) ? 32'h1 : 32'h0, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
